// File: rtl/ascii_parse_pkg.sv
// Shared types and constants for the ASCII decimal parser: FSM states,
// error codes and the special characters it recognises.
package ascii_parse_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_BAD_CHAR = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_EMPTY    = 2'b11;

  localparam logic [7:0] CHAR_ZERO = 8'h30;
  localparam logic [7:0] CHAR_NINE = 8'h39;
  localparam logic [7:0] CHAR_CR   = 8'h0D;
  localparam logic [7:0] CHAR_STAR = 8'h2A;
  localparam logic [7:0] CHAR_BS   = 8'h08;

endpackage

// File: rtl/ascii_digit_stack.sv
// Small LIFO of 4-bit decimal digits; entry 0 is the first (most significant)
// digit pushed, so rd_idx walks the number MSB-first.
module ascii_digit_stack #(
  parameter int DEPTH = 5,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clear,
  input  logic [3:0]    din,
  input  logic [CW-1:0] rd_idx,
  output logic [CW-1:0] count,
  output logic [3:0]    rd_data
);

  logic [3:0] mem [DEPTH];

  // Clear wins over push, push over pop; writes past DEPTH are dropped.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (push && (count < CW'(DEPTH))) begin
      mem[count] <= din;
      count      <= count + CW'(1);
    end else if (pop && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign rd_data = (int'(rd_idx) < DEPTH) ? mem[rd_idx] : 4'h0;

endmodule

// File: rtl/ascii_to_num_parser.sv
// Streams ASCII digits into a buffer and, on the terminator, converts them to a
// 16-bit value one digit per cycle. Optional backspace: ASCII_PARSE_BACKSPACE_EN.
module ascii_to_num_parser
  import ascii_parse_pkg::*;
#(
  parameter int         MAX_DIGITS = 5,
  parameter logic [7:0] TERM_CHAR  = CHAR_CR,
  parameter logic [7:0] CLR_CHAR   = CHAR_STAR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [15:0] num,
  output logic        num_valid,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam int CW = $clog2(MAX_DIGITS + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, idx;
  logic [3:0]    rd_data, digit_val;
  logic [16:0]   acc;
  logic          ovf;
  logic [20:0]   acc_wide, acc_nxt;
  logic          accept, is_digit;
  logic          push, pop, clear, acc_clr, acc_step, load_num, err_set;
  logic [1:0]    err_code_nxt;

  assign accept    = char_valid & char_ready;
  assign is_digit  = (char_in >= CHAR_ZERO) && (char_in <= CHAR_NINE);
  assign digit_val = char_in[3:0] - CHAR_ZERO[3:0];

  // Shift-and-add *10, computed wide so an out-of-range step is still caught.
  assign acc_wide = {4'b0, acc};
  assign acc_nxt  = (acc_wide << 3) + (acc_wide << 1) + {17'b0, rd_data};

  ascii_digit_stack #(.DEPTH(MAX_DIGITS)) u_stack (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .clear   (clear),
    .din     (digit_val),
    .rd_idx  (idx),
    .count   (count),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt    = state;
    char_ready   = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    acc_clr      = 1'b0;
    acc_step     = 1'b0;
    load_num     = 1'b0;
    err_set      = 1'b0;
    err_code_nxt = ERR_NONE;
    case (state)
      IDLE, ACCUM: begin
        char_ready = 1'b1;
        if (accept) begin
          if (is_digit) begin
            if (count == CW'(MAX_DIGITS)) begin
              err_set      = 1'b1;
              err_code_nxt = ERR_OVERFLOW;
              clear        = 1'b1;
              state_nxt    = IDLE;
            end else begin
              push      = 1'b1;
              state_nxt = ACCUM;
            end
          end else if (char_in == CLR_CHAR) begin
            clear     = 1'b1;
            state_nxt = IDLE;
          end else if (char_in == TERM_CHAR) begin
            if (count == '0) begin
              err_set      = 1'b1;
              err_code_nxt = ERR_EMPTY;
              state_nxt    = IDLE;
            end else begin
              acc_clr   = 1'b1;
              state_nxt = CONVERT;
            end
          end
`ifdef ASCII_PARSE_BACKSPACE_EN
          else if (char_in == CHAR_BS) begin
            if (count != '0) begin
              pop = 1'b1;
              if (count == CW'(1)) state_nxt = IDLE;
            end
          end
`endif
          else begin
            err_set      = 1'b1;
            err_code_nxt = ERR_BAD_CHAR;
          end
        end
      end
      CONVERT: begin
        acc_step = 1'b1;
        if (idx == count - CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        clear     = 1'b1;
        state_nxt = IDLE;
        if (ovf) begin
          err_set      = 1'b1;
          err_code_nxt = ERR_OVERFLOW;
        end else begin
          load_num = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result and error flags are registered, so they pulse the cycle after the decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
      num       <= '0;
      num_valid <= 1'b0;
      err       <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      num_valid <= load_num;
      err       <= err_set;
      err_code  <= err_code_nxt;
      if (acc_clr) begin
        acc <= '0;
        idx <= '0;
        ovf <= 1'b0;
      end else if (acc_step) begin
        acc <= acc_nxt[16:0];
        idx <= idx + CW'(1);
        ovf <= ovf | (acc_nxt > 21'd65535);
      end
      if (load_num) num <= acc[15:0];
    end
  end

endmodule

// File: tb/tb_ascii_to_num_parser.sv
// Directed bench for ascii_to_num_parser: hand-computed results for commits,
// overflow, bad characters, clear, backspace and reset during conversion.
module tb_ascii_to_num_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [15:0] num;
  logic        num_valid;
  logic        err;
  logic [1:0]  err_code;

  int vec_count  = 0;
  int miss_count = 0;

  localparam logic [7:0] CR   = 8'h0D;
  localparam logic [7:0] STAR = 8'h2A;
  localparam logic [7:0] BS   = 8'h08;

  ascii_to_num_parser dut (
    .clk        (clk),
    .rst        (rst),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .num        (num),
    .num_valid  (num_valid),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    vec_count++;
    if (act !== exp_v) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp_v);
    end
  endtask

  // Offer one character; exp_code 0 means no error pulse is expected.
  task automatic applyStimulus(input logic [7:0] c, input logic [1:0] exp_code);
    @(negedge clk);
    checkOutput("ready_before_char", 32'(char_ready), 1);
    char_in    = c;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    char_in    = 8'h41;
    checkOutput("err_pulse", 32'(err), 32'(exp_code != 2'b00));
    if (exp_code != 2'b00) checkOutput("err_code", 32'(err_code), 32'(exp_code));
    checkOutput("no_num_valid", 32'(num_valid), 0);
  endtask

  task automatic typeString(input string s);
    for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 2'b00);
  endtask

  // Terminate an n-digit entry; a bad char is held on the bus while busy.
  task automatic commitCheck(input int n, input bit exp_ok, input logic [15:0] exp_num);
    @(negedge clk);
    checkOutput("ready_before_term", 32'(char_ready), 1);
    char_in    = CR;
    char_valid = 1'b1;
    @(negedge clk);
    char_in = 8'h41;
    for (int k = 0; k <= n; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput("busy_ready_low", 32'(char_ready), 0);
      checkOutput("busy_no_pulse", 32'(num_valid | err), 0);
    end
    @(negedge clk);
    char_valid = 1'b0;
    checkOutput("num_valid", 32'(num_valid), 32'(exp_ok));
    checkOutput("commit_err", 32'(err), 32'(!exp_ok));
    if (!exp_ok) checkOutput("commit_err_code", 32'(err_code), 2);
    checkOutput("num", 32'(num), 32'(exp_num));
    checkOutput("ready_after_commit", 32'(char_ready), 1);
    @(negedge clk);
    checkOutput("pulse_one_cycle", 32'(num_valid | err), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("rst_num", 32'(num), 0);
    checkOutput("rst_num_valid", 32'(num_valid), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_err_code", 32'(err_code), 0);
    rst = 1'b0;

    // Idle bus with garbage and valid low must do nothing
    char_in = 8'h41;
    repeat (3) @(negedge clk);
    checkOutput("ignore_invalid", 32'(err | num_valid), 0);

    typeString("123");
    commitCheck(3, 1'b1, 16'd123);

    typeString("65535");
    commitCheck(5, 1'b1, 16'd65535);

    typeString("65536");
    commitCheck(5, 1'b0, 16'd65535);

    typeString("12345");
    applyStimulus("6", 2'b10);
    applyStimulus(CR, 2'b11);

    applyStimulus("4", 2'b00);
    applyStimulus("A", 2'b01);
    applyStimulus(8'h2F, 2'b01);
    applyStimulus(8'h3A, 2'b01);
    applyStimulus("2", 2'b00);
    commitCheck(2, 1'b1, 16'd42);

    typeString("98");
`ifdef ASCII_PARSE_BACKSPACE_EN
    applyStimulus(BS, 2'b00);
    applyStimulus("7", 2'b00);
    commitCheck(2, 1'b1, 16'd97);
`else
    applyStimulus(BS, 2'b01);
    applyStimulus("7", 2'b00);
    commitCheck(3, 1'b1, 16'd987);
`endif

    applyStimulus("5", 2'b00);
    applyStimulus(STAR, 2'b00);
    applyStimulus(CR, 2'b11);

    typeString("007");
    commitCheck(3, 1'b1, 16'd7);

    typeString("99999");
    commitCheck(5, 1'b0, 16'd7);

    // Reset two cycles into a conversion
    typeString("99999");
    @(negedge clk);
    char_in    = CR;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_abort_num", 32'(num), 0);
    @(negedge clk);
    checkOutput("ready_after_release", 32'(char_ready), 1);
    for (int k = 0; k < 8; k++) begin
      checkOutput("no_pulse_after_abort", 32'(num_valid | err), 0);
      @(negedge clk);
    end
    checkOutput("num_after_abort", 32'(num), 0);

    typeString("12");
    commitCheck(2, 1'b1, 16'd12);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/ascii_to_num_parser.md
ASCII_TO_NUM_PARSER -- requirements
Module: ascii_to_num_parser

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 5, meaning the maximum decimal digits buffered per entry.
REQ-002 SHALL have parameter TERM_CHAR, default 8'h0D, meaning the commit character.
REQ-003 SHALL have parameter CLR_CHAR, default 8'h2A ('*'), meaning the clear-entry character.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic samples on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-006 SHALL have port char_in, input, 8, the ASCII character offered.
REQ-007 SHALL have port char_valid, input, 1, meaning char_in is offered this cycle.
REQ-008 SHALL have port char_ready, output, 1; a character is accepted when char_valid and char_ready are both high.
REQ-009 SHALL have port num, output, 16, the last committed value, held until the next commit.
REQ-010 SHALL have port num_valid, output, 1, a one-cycle pulse marking a new num.
REQ-011 SHALL have port err, output, 1, a one-cycle error pulse.
REQ-012 SHALL have port err_code, output, 2, with 01 = bad char, 10 = overflow and 11 = empty commit, valid while err is high.

Function
REQ-013 SHALL implement states IDLE (buffer empty), ACCUM (1..MAX_DIGITS digits buffered), CONVERT and DONE.
REQ-014 SHALL drive char_ready high in IDLE and ACCUM, and low in CONVERT and DONE.
REQ-015 SHALL, on an accepted '0'..'9' (8'h30..8'h39), push char_in-8'h30 into the digit buffer and go to ACCUM; leading zeros count as digits.
REQ-016 SHALL, on an accepted digit when the buffer already holds MAX_DIGITS digits, pulse err with code 10, clear the buffer and go to IDLE.
REQ-017 SHALL, on an accepted CLR_CHAR, clear the buffer and go to IDLE with no err and no num_valid.
REQ-018 SHALL, on an accepted TERM_CHAR with an empty buffer, pulse err with code 11 in the next cycle and stay in IDLE.
REQ-019 SHALL, on an accepted TERM_CHAR with n digits buffered, enter CONVERT and spend exactly n cycles, one digit per cycle from most significant: acc <= acc*10 + d, with acc 17 bits wide and cleared on entry.
REQ-020 SHALL compute *10 as (acc<<3)+(acc<<1), with no multiplier.
REQ-021 SHALL, in DONE (one cycle after the final CONVERT cycle), load num with acc[15:0] and pulse num_valid if acc <= 65535; otherwise it SHALL pulse err with code 10 and leave num unchanged.
REQ-022 SHALL clear the buffer and go to IDLE from DONE, so that num_valid/err occur n+1 cycles after the terminator-accept edge.
REQ-023 SHALL treat any other accepted character as bad: pulse err with code 01 in the next cycle and keep the buffer and state unchanged.
REQ-024 SHALL ignore char_in while char_valid is low.
REQ-025 SHALL never assert num_valid and err in the same cycle.

Reset
REQ-026 SHALL, with rst high at a clock edge, set the state to IDLE, empty the buffer, num=0, num_valid=0, err=0, err_code=00 and acc=0.
REQ-027 SHALL have reset override everything: a CONVERT aborted by reset produces no num_valid, and char_ready is 1 in the first cycle after rst deasserts.

Configuration
REQ-028 SHALL honour macro ASCII_PARSE_BACKSPACE_EN: when defined, accepted 8'h08 pops the newest digit (going to IDLE if the buffer becomes empty) and is a no-op with an empty buffer; when undefined, 8'h08 is a bad char (code 01).

Structure
REQ-029 SHALL place the state enum, err_code constants and the character constants (digit range, 8'h0D, 8'h2A, 8'h08) in shared package ascii_parse_pkg.
REQ-030 SHALL hold the digits in one sub-module, ascii_digit_stack: a MAX_DIGITS x 4-bit push/pop/clear store with count and indexed read, MSB-first.

Verification
REQ-031 SHALL cover: "1","2","3",0x0D -> num_valid with num=123 exactly 4 cycles after the 0x0D accept; char_ready low for those cycles.
REQ-032 SHALL cover: "65535",0x0D -> num=65535; "65536",0x0D -> err code 10, num holds its previous value.
REQ-033 SHALL cover: "123456" -> err code 10 on the 6th digit, buffer empty; then 0x0D -> err code 11.
REQ-034 SHALL cover: "4","A","2",0x0D -> err code 01 after "A", then num=42.
REQ-035 SHALL cover: "98",0x08,"7",0x0D -> num=97 with BACKSPACE_EN, and err code 01 at 0x08 (then num=987) without it; "5","*",0x0D -> err code 11.
REQ-036 SHALL cover: rst asserted mid-CONVERT of "99999" -> no num_valid, num=0, char_ready=1 the cycle after release.
